seg7_anim_scheduler: RTL and testbench
======================================

// Module: seg7_anim_scheduler
// PURPOSE
//   Controller for the seven-segment animation datapath: selects the active animation
//   (0..NUM_ANI-1), generates the step timebase and drives the step index fed to seg7.
//   Animation advances on a debounced push-button press, or automatically after a set
//   number of full loops. Sits between the top-level pins and seg7, replacing the raw
//   switch select and the free-running step counter.
// PARAMETERS
//   TICK_COUNT      24'd10_000_000  step period P when speed_in==0 (step = P+1 clk cycles)
//   DEBOUNCE_CYCLES 16'd50_000      consecutive stable samples needed to accept a button level
//   NUM_ANI         6               number of animations; legal range 2..8
//   LOOPS_PER_ANI   3               full loops per animation in auto mode; legal range 1..15
// PORTS
//   clk          in   1   system clock
//   rst_n        in   1   asynchronous reset, active low
//   ena          in   1   design enable; low freezes all state except synchroniser/debouncer
//   btn_next     in   1   raw push-button, asynchronous, active high
//   auto_en      in   1   1 = auto-advance animation after LOOPS_PER_ANI loops
//   speed_in     in   8   0 = use TICK_COUNT; else P = {6'b0, speed_in, 10'b0}
//   animation    out  3   active animation index to seg7
//   digit        out  4   current step index to seg7, 0..limit(animation)
//   frame_tick   out  1   one-cycle pulse, high in the cycle digit takes a new value
//   ani_changed  out  1   one-cycle pulse, high in the cycle animation takes a new value
// BEHAVIOUR
//   Clock/reset: one clock, asynchronous active-low reset. rst_n=0 -> animation=0, digit=0,
//     prescaler=0, loop_cnt=0, debounced level=0, frame_tick=0, ani_changed=0, state=RUN.
//   Limit table (last step, inclusive): ani0=9, ani1=6, ani2=6, ani3=6, ani4=5, ani5=5,
//     ani6=9, ani7=9. All outputs registered.
//   Button path: 2-flop synchroniser; debounce counter resets whenever sample != current
//     debounced level; when it reaches DEBOUNCE_CYCLES-1 the debounced level takes the
//     sample. Press event = debounced 0->1, one cycle. Release generates no event.
//   Prescaler (24 bit): if ena && prescaler >= P -> prescaler<=0, step event; else +1.
//     '>=' guarantees no lock-out if speed_in shrinks P mid-count.
//   Step event: digit <= (digit==limit) ? 0 : digit+1; frame_tick=1 same cycle as new digit.
//     On digit wrap to 0: loop_cnt+1; if auto_en && loop_cnt==LOOPS_PER_ANI-1 -> switch req.
//   FSM: RUN -> SWITCH on (press event && ena) or auto switch req. SWITCH lasts 1 cycle:
//     animation <= (animation==NUM_ANI-1) ? 0 : animation+1; digit<=0; prescaler<=0;
//     loop_cnt<=0; ani_changed=1 in the cycle the new animation is visible; then -> RUN.
//     No step events during SWITCH. Press arriving during SWITCH is dropped.
//   Simultaneous press and auto request in same cycle: exactly one advance.
//   Wrap that triggers a switch: digit shows 0 (frame_tick=1), next cycle animation changes.
//   auto_en low: loop_cnt still counts but saturates at LOOPS_PER_ANI-1; re-enabling with
//     loop_cnt saturated switches on the next wrap.
//   ena low: prescaler, digit, loop_cnt, animation, FSM hold; press events discarded;
//     frame_tick and ani_changed forced 0.
//   Reset mid-SWITCH or mid-count: immediate return to reset values, no pulse emitted.
// TESTING (sim params TICK_COUNT=4, DEBOUNCE_CYCLES=8, LOOPS_PER_ANI=2)
//   1 Reset: assert rst_n=0 mid-run -> animation=0, digit=0, pulses 0 without clk edge.
//   2 Timebase: ena=1, speed_in=0 -> frame_tick every 5 cycles; digit 0..9 then 0 on ani0.
//   3 Debounce: btn glitches of 3 cycles x5 -> no change; hold 20 cycles -> single advance
//     to ani1, ani_changed one pulse, digit=0; release -> no further change.
//   4 Auto: auto_en=1 on ani1 -> after 2 wraps (14 steps) animation=2, digit=0;
//     five more auto advances reach ani5 -> ani0 wrap with NUM_ANI=6.
//   5 Speed change: speed_in=1 with prescaler near 1023, then speed_in=0 -> wraps next
//     cycle, no hang; frame_tick period returns to 5.
//   6 Collision/enable: press event coinciding with auto request -> advance by 1 only;
//     ena=0 during press -> no advance, all outputs frozen.

Source files
------------

// File: rtl/seg7_anim_scheduler.sv
// Animation scheduler for the seven-segment datapath: button/auto animation select,
// step timebase and step index generation.
module seg7_anim_scheduler #(
   parameter logic [23:0] TICK_COUNT      = 24'd10_000_000,
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50_000,
   parameter int unsigned NUM_ANI         = 6,
   parameter int unsigned LOOPS_PER_ANI   = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       btn_next,
   input  logic       auto_en,
   input  logic [7:0] speed_in,
   output logic [2:0] animation,
   output logic [3:0] digit,
   output logic       frame_tick,
   output logic       ani_changed
);

   localparam int unsigned PRESC_W = 24;
   localparam int unsigned DB_W    = 16;
   localparam int unsigned ANI_W   = 3;
   localparam int unsigned DIG_W   = 4;
   localparam int unsigned LOOP_W  = 4;

   localparam logic [ANI_W-1:0]  LAST_ANI  = ANI_W'(NUM_ANI - 1);
   localparam logic [LOOP_W-1:0] LAST_LOOP = LOOP_W'(LOOPS_PER_ANI - 1);
   localparam logic [DB_W-1:0]   DB_LAST   = DEBOUNCE_CYCLES - DB_W'(1);

   typedef enum logic {RUN, SWITCH} state_t;

   state_t               state;
   logic [PRESC_W-1:0]   prescaler;
   logic [LOOP_W-1:0]    loop_cnt;
   logic                 btn_meta;
   logic                 btn_sync;
   logic [DB_W-1:0]      db_cnt;
   logic                 db_level;
   logic                 press;

   logic [PRESC_W-1:0]   period_c;
   logic [DIG_W-1:0]     limit_c;
   logic                 db_take_c;
   logic                 step_c;
   logic                 wrap_c;
   logic                 auto_req_c;
   logic                 go_switch_c;

   // Last step index (inclusive) of each animation.
   function automatic logic [DIG_W-1:0] limit_of(input logic [ANI_W-1:0] ani);
      logic [DIG_W-1:0] lim;
      case (ani)
         3'd1, 3'd2, 3'd3: lim = 4'd6;
         3'd4, 3'd5:       lim = 4'd5;
         default:          lim = 4'd9;
      endcase
      return lim;
   endfunction

   always_comb begin
      period_c    = (speed_in == 8'd0) ? TICK_COUNT : {6'b0, speed_in, 10'b0};
      limit_c     = limit_of(animation);
      db_take_c   = (btn_sync != db_level) && (db_cnt == DB_LAST);
      step_c      = ena && (state == RUN) && (prescaler >= period_c);
      wrap_c      = (digit >= limit_c);
      auto_req_c  = step_c && wrap_c && auto_en && (loop_cnt == LAST_LOOP);
      go_switch_c = ena && (state == RUN) && (press || auto_req_c);
   end

   // Button synchroniser and debouncer run regardless of ena.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_meta <= 1'b0;
         btn_sync <= 1'b0;
         db_cnt   <= '0;
         db_level <= 1'b0;
         press    <= 1'b0;
      end else begin
         btn_meta <= btn_next;
         btn_sync <= btn_meta;
         press    <= db_take_c && btn_sync;
         if (btn_sync == db_level) begin
            db_cnt <= '0;
         end else if (db_take_c) begin
            db_cnt   <= '0;
            db_level <= btn_sync;
         end else begin
            db_cnt <= db_cnt + DB_W'(1);
         end
      end
   end

   // Timebase, step index, loop counting and the RUN/SWITCH sequencer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= RUN;
         prescaler   <= '0;
         loop_cnt    <= '0;
         animation   <= '0;
         digit       <= '0;
         frame_tick  <= 1'b0;
         ani_changed <= 1'b0;
      end else begin
         frame_tick  <= 1'b0;
         ani_changed <= 1'b0;
         if (ena) begin
            case (state)
               RUN: begin
                  if (step_c) begin
                     prescaler  <= '0;
                     frame_tick <= 1'b1;
                     if (wrap_c) begin
                        digit <= '0;
                        if (loop_cnt != LAST_LOOP)
                           loop_cnt <= loop_cnt + LOOP_W'(1);
                     end else begin
                        digit <= digit + DIG_W'(1);
                     end
                  end else begin
                     prescaler <= prescaler + PRESC_W'(1);
                  end
                  if (go_switch_c)
                     state <= SWITCH;
               end
               SWITCH: begin
                  animation   <= (animation >= LAST_ANI) ? '0 : animation + ANI_W'(1);
                  digit       <= '0;
                  prescaler   <= '0;
                  loop_cnt    <= '0;
                  ani_changed <= 1'b1;
                  state       <= RUN;
               end
               default: state <= RUN;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_seg7_anim_scheduler.sv
// Directed bench for seg7_anim_scheduler: vector table plus hand-timed corner sequences.
module tb_seg7_anim_scheduler;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic       btn_next;
   logic       auto_en;
   logic [7:0] speed_in;
   logic [2:0] animation;
   logic [3:0] digit;
   logic       frame_tick;
   logic       ani_changed;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int unsigned n;
      logic        ena;
      logic        btn;
      logic        auto_en;
      logic [7:0]  speed;
      logic [2:0]  ani;
      logic [3:0]  dig;
      logic        ft;
      logic        ac;
   } vec_t;

   vec_t vecs [25];

   seg7_anim_scheduler #(
      .TICK_COUNT     (24'd4),
      .DEBOUNCE_CYCLES(16'd8),
      .NUM_ANI        (6),
      .LOOPS_PER_ANI  (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .btn_next   (btn_next),
      .auto_en    (auto_en),
      .speed_in   (speed_in),
      .animation  (animation),
      .digit      (digit),
      .frame_tick (frame_tick),
      .ani_changed(ani_changed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [2:0] a, input logic [3:0] d,
                            input logic ft, input logic ac);
      check({tag, " animation"},   32'(animation),   32'(a));
      check({tag, " digit"},       32'(digit),       32'(d));
      check({tag, " frame_tick"},  32'(frame_tick),  32'(ft));
      check({tag, " ani_changed"}, 32'(ani_changed), 32'(ac));
   endtask

   function automatic vec_t mk(input int unsigned n, input logic e, input logic b,
                               input logic au, input logic [7:0] sp, input logic [2:0] a,
                               input logic [3:0] d, input logic ft, input logic ac);
      vec_t v;
      v.n = n; v.ena = e; v.btn = b; v.auto_en = au; v.speed = sp;
      v.ani = a; v.dig = d; v.ft = ft; v.ac = ac;
      return v;
   endfunction

   task automatic apply_range(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         ena      = vecs[i].ena;
         btn_next = vecs[i].btn;
         auto_en  = vecs[i].auto_en;
         speed_in = vecs[i].speed;
         tick(int'(vecs[i].n));
         check_out($sformatf("vec%0d", i), vecs[i].ani, vecs[i].dig, vecs[i].ft, vecs[i].ac);
      end
   endtask

   initial begin
      // Timebase, enable freeze and discarded press while disabled.
      vecs[0]  = mk(5,  1, 0, 0, 8'd0, 3'd0, 4'd1, 1, 0);
      vecs[1]  = mk(1,  1, 0, 0, 8'd0, 3'd0, 4'd1, 0, 0);
      vecs[2]  = mk(4,  1, 0, 0, 8'd0, 3'd0, 4'd2, 1, 0);
      vecs[3]  = mk(40, 1, 0, 0, 8'd0, 3'd0, 4'd0, 1, 0);
      vecs[4]  = mk(5,  1, 0, 0, 8'd0, 3'd0, 4'd1, 1, 0);
      vecs[5]  = mk(7,  0, 0, 0, 8'd0, 3'd0, 4'd1, 0, 0);
      vecs[6]  = mk(5,  1, 0, 0, 8'd0, 3'd0, 4'd2, 1, 0);
      vecs[7]  = mk(20, 0, 1, 0, 8'd0, 3'd0, 4'd2, 0, 0);
      vecs[8]  = mk(20, 0, 0, 0, 8'd0, 3'd0, 4'd2, 0, 0);
      vecs[9]  = mk(5,  1, 0, 0, 8'd0, 3'd0, 4'd3, 1, 0);
      // Five 3-cycle glitches on the button: steps continue, no advance.
      vecs[10] = mk(3,  1, 1, 0, 8'd0, 3'd0, 4'd3, 0, 0);
      vecs[11] = mk(3,  1, 0, 0, 8'd0, 3'd0, 4'd4, 0, 0);
      vecs[12] = mk(3,  1, 1, 0, 8'd0, 3'd0, 4'd4, 0, 0);
      vecs[13] = mk(3,  1, 0, 0, 8'd0, 3'd0, 4'd5, 0, 0);
      vecs[14] = mk(3,  1, 1, 0, 8'd0, 3'd0, 4'd6, 1, 0);
      vecs[15] = mk(3,  1, 0, 0, 8'd0, 3'd0, 4'd6, 0, 0);
      vecs[16] = mk(3,  1, 1, 0, 8'd0, 3'd0, 4'd7, 0, 0);
      vecs[17] = mk(3,  1, 0, 0, 8'd0, 3'd0, 4'd7, 0, 0);
      vecs[18] = mk(3,  1, 1, 0, 8'd0, 3'd0, 4'd8, 0, 0);
      vecs[19] = mk(3,  1, 0, 0, 8'd0, 3'd0, 4'd9, 1, 0);
      // Auto advance chain ani2 -> 3 -> 4 -> 5 -> 0 -> 1, two loops each.
      vecs[20] = mk(71,  1, 0, 1, 8'd0, 3'd3, 4'd0, 0, 1);
      vecs[21] = mk(71,  1, 0, 1, 8'd0, 3'd4, 4'd0, 0, 1);
      vecs[22] = mk(61,  1, 0, 1, 8'd0, 3'd5, 4'd0, 0, 1);
      vecs[23] = mk(61,  1, 0, 1, 8'd0, 3'd0, 4'd0, 0, 1);
      vecs[24] = mk(101, 1, 0, 1, 8'd0, 3'd1, 4'd0, 0, 1);

      rst_n    = 1'b0;
      ena      = 1'b0;
      btn_next = 1'b0;
      auto_en  = 1'b0;
      speed_in = 8'd0;
      tick(2);
      check_out("reset", 3'd0, 4'd0, 0, 0);
      rst_n = 1'b1;
      ena   = 1'b1;

      apply_range(0, 19);

      // Held press: single advance to ani1 with one ani_changed pulse.
      btn_next = 1'b1;
      tick(11);
      check_out("press_pre", 3'd0, 4'd1, 0, 0);
      tick(1);
      check_out("press_switch", 3'd1, 4'd0, 0, 1);
      tick(1);
      check("press_pulse_end", 32'(ani_changed), 32'd0);
      tick(7);
      btn_next = 1'b0;
      tick(20);
      check_out("press_release", 3'd1, 4'd5, 0, 0);

      // Auto advance after two wraps of ani1.
      auto_en = 1'b1;
      tick(42);
      check_out("auto_wrap", 3'd1, 4'd0, 1, 0);
      tick(1);
      check_out("auto_switch", 3'd2, 4'd0, 0, 1);

      apply_range(20, 24);

      // Speed change shrinking the period mid-count.
      auto_en  = 1'b0;
      speed_in = 8'd1;
      tick(1020);
      check_out("slow_count", 3'd1, 4'd0, 0, 0);
      speed_in = 8'd0;
      tick(1);
      check_out("speed_drop", 3'd1, 4'd1, 1, 0);
      tick(5);
      check_out("speed_p5a", 3'd1, 4'd2, 1, 0);
      tick(4);
      check_out("speed_gap", 3'd1, 4'd2, 0, 0);
      tick(1);
      check_out("speed_p5b", 3'd1, 4'd3, 1, 0);

      // Press event landing on the auto-switch wrap: one advance only.
      auto_en = 1'b1;
      tick(44);
      btn_next = 1'b1;
      tick(10);
      check_out("coll_pre", 3'd1, 4'd6, 0, 0);
      tick(1);
      check_out("coll_wrap", 3'd1, 4'd0, 1, 0);
      tick(1);
      check_out("coll_switch", 3'd2, 4'd0, 0, 1);
      auto_en = 1'b0;
      tick(20);
      check_out("coll_hold", 3'd2, 4'd4, 1, 0);
      btn_next = 1'b0;
      tick(20);
      check_out("coll_release", 3'd2, 4'd1, 1, 0);

      // Asynchronous reset mid-cycle while frame_tick is high.
      #2;
      rst_n = 1'b0;
      #1;
      check_out("async_reset", 3'd0, 4'd0, 0, 0);
      tick(3);
      rst_n = 1'b1;
      tick(4);
      check_out("post_reset_gap", 3'd0, 4'd0, 0, 0);
      tick(1);
      check_out("post_reset_step", 3'd0, 4'd1, 1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
